md_unit: RTL and testbench

E-stage multiply/divide unit that produces the HI/LO value which travels down the pipeline to the W-stage writeback mux (the MUXMDSrc path).
- Executes mult/multu/div/divu over multiple cycles.
- Services mthi/mtlo writes and mfhi/mflo reads.
- Exports busy so the hazard unit can stall D-stage MD instructions.

---
 rtl/md_pkg.sv | 25 ++
 rtl/md_calc.sv | 40 ++++
 rtl/md_unit.sv | 55 +++++
 tb/tb_md_unit.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared op encodings, FSM states and op-class helpers for md_unit (MD_MADD_EN adds madd/maddu launch ops)
package md_pkg;
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;
  function automatic logic is_md_start(input logic [3:0] op);
`ifdef MD_MADD_EN
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU};
`else
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
`endif
  endfunction
  function automatic logic is_md_div(input logic [3:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
endpackage

// File: rtl/md_calc.sv
// md_calc: combinational 64-bit HI/LO result generator; ports i_op/i_a/i_b/i_hi/i_lo in, o_hi_t/o_lo_t out; MD_MADD_EN enables accumulate ops
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [31:0] o_hi_t,
  output logic [31:0] o_lo_t
);
  logic [63:0] w_sprod, w_uprod, w_res;
  logic [31:0] w_abs_a, w_abs_b, w_uq, w_ur, w_squo, w_srem;
  assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};
  // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 deterministically
  assign w_abs_a = i_a[31] ? -i_a : i_a;
  assign w_abs_b = i_b[31] ? -i_b : i_b;
  assign w_uq    = w_abs_a / w_abs_b;
  assign w_ur    = w_abs_a % w_abs_b;
  assign w_squo  = (i_a[31] ^ i_b[31]) ? -w_uq : w_uq;
  assign w_srem  = i_a[31] ? -w_ur : w_ur;
  // Unlisted ops and zero divisors hand back the current HI/LO, so the final commit is a no-op
  always_comb begin
    w_res = {i_hi, i_lo};
    case (i_op)
      MD_MULT:  w_res = w_sprod;
      MD_MULTU: w_res = w_uprod;
      MD_DIV:   w_res = (i_b != 32'd0) ? {w_srem, w_squo} : {i_hi, i_lo};
      MD_DIVU:  w_res = (i_b != 32'd0) ? {i_a % i_b, i_a / i_b} : {i_hi, i_lo};
`ifdef MD_MADD_EN
      MD_MADD:  w_res = {i_hi, i_lo} + w_sprod;
      MD_MADDU: w_res = {i_hi, i_lo} + w_uprod;
`endif
      default:  w_res = {i_hi, i_lo};
    endcase
  end
  assign {o_hi_t, o_lo_t} = w_res;
endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multi-cycle multiply/divide with HI/LO; ports clk, reset (async low), E_MDOp/E_Start/E_RS_D/E_RT_D in, E_Busy/E_HI/E_LO/E_MD_O out; MD_MADD_EN adds madd/maddu
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic        E_Start,
  input  logic [31:0] E_RS_D,
  input  logic [31:0] E_RT_D,
  output logic        E_Busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO,
  output logic [31:0] E_MD_O
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  md_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_hi_t, r_lo_t, w_hi_t, w_lo_t;
  md_calc u_calc (
    .i_op(E_MDOp), .i_a(E_RS_D), .i_b(E_RT_D), .i_hi(E_HI), .i_lo(E_LO),
    .o_hi_t(w_hi_t), .o_lo_t(w_lo_t)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi_t  <= '0;
      r_lo_t  <= '0;
      E_HI    <= '0;
      E_LO    <= '0;
    end else if (r_state == IDLE) begin
      if (E_Start && is_md_start(E_MDOp)) begin
        r_hi_t  <= w_hi_t;
        r_lo_t  <= w_lo_t;
        r_cnt   <= is_md_div(E_MDOp) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        r_state <= BUSY;
      end else if (E_MDOp == MD_MTHI) E_HI <= E_RS_D;
      else if (E_MDOp == MD_MTLO) E_LO <= E_RS_D;
    end else begin
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        E_HI    <= r_hi_t;
        E_LO    <= r_lo_t;
        r_state <= IDLE;
      end
    end
  end
  assign E_Busy = (r_state == BUSY);
  assign E_MD_O = (E_MDOp == MD_MFHI) ? E_HI : (E_MDOp == MD_MFLO) ? E_LO : 32'd0;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit
module tb_md_unit;
  import md_pkg::*;
  logic        clk = 0, reset = 0, E_Start = 0, E_Busy;
  logic [3:0]  E_MDOp = MD_NONE;
  logic [31:0] E_RS_D = 0, E_RT_D = 0, E_HI, E_LO, E_MD_O;
  int n_chk = 0, n_fail = 0, n;
  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_MDOp(E_MDOp), .E_Start(E_Start), .E_RS_D(E_RS_D),
    .E_RT_D(E_RT_D), .E_Busy(E_Busy), .E_HI(E_HI), .E_LO(E_LO), .E_MD_O(E_MD_O)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    E_MDOp = op; E_RS_D = a; E_RT_D = b; E_Start = 1;
    @(negedge clk);
    E_Start = 0; E_MDOp = MD_NONE;
  endtask
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (E_Busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask
  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    @(negedge clk);
    E_MDOp = op; E_RS_D = v;
    @(negedge clk);
    E_MDOp = MD_NONE;
  endtask
  initial begin
    #12;
    check("rst_busy", {31'd0, E_Busy}, 0);
    check("rst_hi", E_HI, 0);
    check("rst_lo", E_LO, 0);
    @(negedge clk); reset = 1;
    // 1: reset mid-div
    mt(MD_MTHI, 32'h11111111);
    mt(MD_MTLO, 32'h22222222);
    check("mthi_pre", E_HI, 32'h11111111);
    launch(MD_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("div_inflight", {31'd0, E_Busy}, 1);
    #2 reset = 0;
    #1;
    check("mid_rst_busy", {31'd0, E_Busy}, 0);
    check("mid_rst_hi", E_HI, 0);
    check("mid_rst_lo", E_LO, 0);
    @(negedge clk); reset = 1;
    repeat (15) @(negedge clk);
    check("post_rst_busy", {31'd0, E_Busy}, 0);
    check("post_rst_hi", E_HI, 0);
    check("post_rst_lo", E_LO, 0);
    // 2: mult / multu
    launch(MD_MULT, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    check("mult_busy", n, 5);
    check("mult_hi", E_HI, 32'hFFFFFFFF);
    check("mult_lo", E_LO, 32'hFFFFFFFA);
    launch(MD_MULTU, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    check("multu_busy", n, 5);
    check("multu_hi", E_HI, 32'h00000002);
    check("multu_lo", E_LO, 32'hFFFFFFFA);
    // 3: div / divu by zero / overflow
    launch(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    check("div_busy", n, 10);
    check("div_lo", E_LO, 32'hFFFFFFFD);
    check("div_hi", E_HI, 32'hFFFFFFFF);
    launch(MD_DIVU, 32'd7, 32'd0);
    wait_idle(n);
    check("divu0_busy", n, 10);
    check("divu0_hi", E_HI, 32'hFFFFFFFF);
    check("divu0_lo", E_LO, 32'hFFFFFFFD);
    launch(MD_DIVU, 32'd23, 32'd5);
    wait_idle(n);
    check("divu_lo", E_LO, 32'd4);
    check("divu_hi", E_HI, 32'd3);
    launch(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    check("divovf_lo", E_LO, 32'h80000000);
    check("divovf_hi", E_HI, 32'd0);
    // 4: back-to-back mthi/mtlo, mfhi/mflo
    @(negedge clk);
    E_MDOp = MD_MTHI; E_RS_D = 32'h12345678;
    @(negedge clk);
    check("mthi_hi", E_HI, 32'h12345678);
    check("mthi_lo", E_LO, 32'h80000000);
    E_MDOp = MD_MTLO; E_RS_D = 32'h9ABCDEF0;
    @(negedge clk);
    check("mtlo_lo", E_LO, 32'h9ABCDEF0);
    check("mt_busy", {31'd0, E_Busy}, 0);
    E_MDOp = MD_MFHI; #1;
    check("mfhi", E_MD_O, 32'h12345678);
    E_MDOp = MD_MFLO; #1;
    check("mflo", E_MD_O, 32'h9ABCDEF0);
    E_MDOp = MD_NONE; #1;
    check("md_o_none", E_MD_O, 0);
    // 5: ops during BUSY are ignored
    launch(MD_MULT, 32'h00010000, 32'h00030000);
    n = 0;
    while (E_Busy && n < 100) begin
      if (n == 0) begin E_Start = 1; E_MDOp = MD_DIV; E_RS_D = 32'd9; E_RT_D = 32'd3; end
      else if (n == 1) begin E_Start = 0; E_MDOp = MD_MTLO; E_RS_D = 32'hDEADBEEF; end
      else if (n == 2) begin E_MDOp = MD_MFHI; #1; check("mfhi_busy_old", E_MD_O, 32'h12345678); end
      else E_MDOp = MD_NONE;
      n++;
      @(negedge clk);
    end
    E_MDOp = MD_NONE; E_Start = 0;
    check("ign_busy", n, 5);
    check("ign_hi", E_HI, 32'd3);
    check("ign_lo", E_LO, 32'd0);
    @(negedge clk);
    check("ign_idle", {31'd0, E_Busy}, 0);
    // 6: maddu
    mt(MD_MTHI, 32'd0);
    mt(MD_MTLO, 32'hFFFFFFFF);
    launch(MD_MADDU, 32'd1, 32'd1);
`ifdef MD_MADD_EN
    wait_idle(n);
    check("maddu_busy", n, 5);
    check("maddu_hi", E_HI, 32'd1);
    check("maddu_lo", E_LO, 32'd0);
`else
    check("maddu_nobusy", {31'd0, E_Busy}, 0);
    repeat (6) @(negedge clk);
    check("maddu_hi", E_HI, 32'd0);
    check("maddu_lo", E_LO, 32'hFFFFFFFF);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
